// File: rtl/dm_arbiter_if.sv
// Bus bundle for dm_arbiter: two requester ports plus the single data-memory port.
// Handshake: a requester raises reqN with stable weN/addrN/wdN and holds them until doneN pulses for one cycle.
interface dm_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          req0;
  logic          we0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] wd0;
  logic          req1;
  logic          we1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wd1;
  logic          done0;
  logic          done1;
  logic          err;
  logic [DW-1:0] rdata;
  logic          busy;
  logic          mem_re;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wd;
  logic [DW-1:0] mem_rd;

  // Arbiter side.
  modport slave (
    input  req0, we0, addr0, wd0,
    input  req1, we1, addr1, wd1,
    input  mem_rd,
    output done0, done1, err, rdata, busy,
    output mem_re, mem_we, mem_addr, mem_wd
  );

  // Requester side (pipeline MEM stage and secondary loader).
  modport master (
    output req0, we0, addr0, wd0,
    output req1, we1, addr1, wd1,
    input  done0, done1, err, rdata, busy
  );

  // Data memory side.
  modport memory (
    input  mem_re, mem_we, mem_addr, mem_wd,
    output mem_rd
  );
endinterface

// File: rtl/dm_arbiter.sv
// Two-port arbiter/sequencer for the single-port data memory: IDLE -> ACCESS -> RESP.
// Define DM_ARB_RR_EN for round-robin tie-breaking; otherwise port 0 has fixed priority.
module dm_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic       clk,
  input  logic       reset,
  dm_arbiter_if.slave bus,
  output logic [1:0] state_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          we_q, we_d;
  logic          sel_q, sel_d;
  logic          mis_q, mis_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wd_q, wd_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          gnt1;
  logic [AW-1:0] win_addr;
  logic          in_access;
  logic          in_resp;
  logic          rd_strobe;

`ifdef DM_ARB_RR_EN
  logic          last_q, last_d;

  // On a tie the port that was not served last wins; a lone request always wins.
  always_comb begin
    gnt1 = bus.req1 & (~bus.req0 | ~last_q);
  end
`else
  always_comb begin
    gnt1 = bus.req1 & ~bus.req0;
  end
`endif

  always_comb begin
    win_addr = gnt1 ? bus.addr1 : bus.addr0;
  end

  assign in_access = (state_q == ACCESS);
  assign in_resp   = (state_q == RESP);
  assign rd_strobe = in_access & ~we_q & ~mis_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    sel_d   = sel_q;
    mis_d   = mis_q;
    addr_d  = addr_q;
    wd_d    = wd_q;
    rdata_d = rdata_q;
`ifdef DM_ARB_RR_EN
    last_d  = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.req0 | bus.req1) begin
          sel_d   = gnt1;
          we_d    = gnt1 ? bus.we1 : bus.we0;
          wd_d    = gnt1 ? bus.wd1 : bus.wd0;
          addr_d  = win_addr;
          mis_d   = |win_addr[1:0];
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        // Stores and misaligned requests return zero read data.
        rdata_d = rd_strobe ? bus.mem_rd : '0;
        state_d = RESP;
      end
      RESP: begin
`ifdef DM_ARB_RR_EN
        last_d  = sel_q;
`endif
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      we_q    <= 1'b0;
      sel_q   <= 1'b0;
      mis_q   <= 1'b0;
      addr_q  <= '0;
      wd_q    <= '0;
      rdata_q <= '0;
`ifdef DM_ARB_RR_EN
      last_q  <= 1'b1;
`endif
    end else begin
      we_q    <= we_d;
      sel_q   <= sel_d;
      mis_q   <= mis_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      rdata_q <= rdata_d;
`ifdef DM_ARB_RR_EN
      last_q  <= last_d;
`endif
    end
  end

  // The write strobe is masked by reset so an aborted store never commits.
  assign bus.mem_we   = in_access & we_q & ~mis_q & ~reset;
  assign bus.mem_re   = rd_strobe;
  assign bus.mem_addr = addr_q;
  assign bus.mem_wd   = wd_q;
  assign bus.done0    = in_resp & ~sel_q;
  assign bus.done1    = in_resp & sel_q;
  assign bus.err      = in_resp & mis_q;
  assign bus.rdata    = rdata_q;
  assign bus.busy     = (state_q != IDLE);
  assign state_o      = state_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a small word memory model behind the memory port.
// Expected values are hand-derived from the access timing IDLE -> ACCESS -> RESP.
module tb_dm_arbiter;

  logic        clk;
  logic        reset;
  logic [1:0]  state;
  int          total;
  int          bad;
  logic [31:0] mem [0:63];

  dm_arbiter_if #(.AW(32), .DW(32)) bus ();

  dm_arbiter #(.AW(32), .DW(32)) dut (
    .clk     (clk),
    .reset   (reset),
    .bus     (bus),
    .state_o (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.mem_rd = mem[bus.mem_addr[7:2]];

  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr[7:2]] <= bus.mem_wd;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_req(input int port, input bit req, input bit we,
                         input logic [31:0] addr, input logic [31:0] wd);
    if (port == 0) begin
      bus.req0 = req; bus.we0 = we; bus.addr0 = addr; bus.wd0 = wd;
    end else begin
      bus.req1 = req; bus.we1 = we; bus.addr1 = addr; bus.wd1 = wd;
    end
  endtask

  // One full transaction from an idle start, checking every phase.
  task automatic do_access(input int port, input bit we, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] exp_rd,
                           input bit exp_err, input bit early_drop, input string tag);
    logic [6:0] obs, exp;
    @(posedge clk); #1;
    set_req(port, 1'b1, we, addr, wd);
    @(negedge clk);
    total++;
    if (bus.busy !== 1'b0 || state !== 2'd0) begin
      bad++;
      $display("FAIL %s idle: busy=%b state=%0d want busy=0 state=0", tag, bus.busy, state);
    end
    @(posedge clk); #1;
    if (early_drop) set_req(port, 1'b0, we, addr, wd);
    @(negedge clk);
    obs = {state, bus.busy, bus.mem_we, bus.mem_re, bus.done0, bus.done1};
    exp = {2'd1, 1'b1, we & ~exp_err, ~we & ~exp_err, 1'b0, 1'b0};
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s access {st,busy,we,re,d0,d1}: got %b want %b", tag, obs, exp);
    end
    total++;
    if (bus.mem_addr !== addr) begin
      bad++;
      $display("FAIL %s mem_addr: got %h want %h", tag, bus.mem_addr, addr);
    end
    if (we) begin
      total++;
      if (bus.mem_wd !== wd) begin
        bad++;
        $display("FAIL %s mem_wd: got %h want %h", tag, bus.mem_wd, wd);
      end
    end
    @(posedge clk); #1;
    set_req(port, 1'b0, we, addr, wd);
    @(negedge clk);
    obs = {state, bus.busy, bus.done0, bus.done1, bus.err, bus.mem_we | bus.mem_re};
    exp = {2'd2, 1'b1, port == 0, port == 1, exp_err, 1'b0};
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s resp {st,busy,d0,d1,err,strobe}: got %b want %b", tag, obs, exp);
    end
    total++;
    if (bus.rdata !== exp_rd) begin
      bad++;
      $display("FAIL %s rdata: got %h want %h", tag, bus.rdata, exp_rd);
    end
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if ({bus.busy, bus.done0, bus.done1} !== 3'b000) begin
      bad++;
      $display("FAIL %s after: busy,d0,d1 got %b want 000", tag, {bus.busy, bus.done0, bus.done1});
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    total++;
    if ({state, bus.busy, bus.done0, bus.done1, bus.err, bus.mem_re, bus.mem_we} !== 8'b0) begin
      bad++;
      $display("FAIL reset_ctrl: got %b want 00000000",
               {state, bus.busy, bus.done0, bus.done1, bus.err, bus.mem_re, bus.mem_we});
    end
    total++;
    if ({bus.rdata, bus.mem_addr, bus.mem_wd} !== 96'h0) begin
      bad++;
      $display("FAIL reset_data: rdata=%h addr=%h wd=%h want all 0", bus.rdata, bus.mem_addr, bus.mem_wd);
    end
  endtask

  task automatic test_store_load;
    do_access(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b0, "store0");
    do_access(0, 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0, "load0");
  endtask

  task automatic test_back_to_back;
    do_access(1, 1'b0, 32'h0000_0024, 32'h0, 32'hA500_0009, 1'b0, 1'b0, "load1_init");
    do_access(1, 1'b1, 32'h0000_0024, 32'h0BAD_F00D, 32'h0, 1'b0, 1'b0, "store1");
    do_access(1, 1'b0, 32'h0000_0024, 32'h0, 32'h0BAD_F00D, 1'b0, 1'b0, "load1");
  endtask

  task automatic test_misaligned;
    do_access(1, 1'b0, 32'h0000_0006, 32'h0, 32'h0, 1'b1, 1'b0, "misaligned1");
    do_access(0, 1'b1, 32'h0000_0011, 32'h5555_5555, 32'h0, 1'b1, 1'b0, "misaligned0_st");
    do_access(0, 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0, "no_mis_write");
  endtask

  task automatic test_reset_mid_access;
    @(posedge clk); #1;
    set_req(0, 1'b1, 1'b1, 32'h0000_0020, 32'h1234_5678);
    @(posedge clk); #1;
    reset = 1'b1;
    set_req(0, 1'b0, 1'b1, 32'h0000_0020, 32'h1234_5678);
    @(negedge clk);
    total++;
    if ({state, bus.mem_we} !== 3'b010) begin
      bad++;
      $display("FAIL rst_mid_we {st,we}: got %b want 010", {state, bus.mem_we});
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    total++;
    if ({state, bus.busy, bus.done0, bus.done1} !== 5'b0) begin
      bad++;
      $display("FAIL rst_mid_idle {st,busy,d0,d1}: got %b want 00000",
               {state, bus.busy, bus.done0, bus.done1});
    end
    @(posedge clk); #1;
    @(negedge clk);
    total++;
    if ({bus.done0, bus.done1, bus.busy} !== 3'b0) begin
      bad++;
      $display("FAIL rst_mid_late: d0,d1,busy got %b want 000", {bus.done0, bus.done1, bus.busy});
    end
    do_access(0, 1'b0, 32'h0000_0020, 32'h0, 32'hA500_0008, 1'b0, 1'b0, "rst_mid_reload");
  endtask

  task automatic test_withdraw;
    int pulses;
    do_access(0, 1'b0, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b1, "withdraw");
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (bus.done0) pulses++;
    end
    total++;
    if (pulses !== 0) begin
      bad++;
      $display("FAIL withdraw_extra: got %0d extra done0 pulses want 0", pulses);
    end
  endtask

  // Both ports contend; round-robin alternates, fixed priority serves port 0 only.
  task automatic test_contention;
    logic [7:0] exp_q[$];
    logic [7:0] e;
    int         guard;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
`ifdef DM_ARB_RR_EN
    exp_q = '{{7'd2, 1'b0}, {7'd5, 1'b1}, {7'd8, 1'b0}, {7'd11, 1'b1}};
`else
    exp_q = '{{7'd2, 1'b0}, {7'd5, 1'b0}, {7'd8, 1'b0}, {7'd11, 1'b0}};
`endif
    set_req(0, 1'b1, 1'b0, 32'h0000_0010, 32'h0);
    set_req(1, 1'b1, 1'b0, 32'h0000_0024, 32'h0);
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (cyc > 0) begin
        @(posedge clk); #1;
`ifdef DM_ARB_RR_EN
        bus.req0 = ~bus.done0;
        bus.req1 = ~bus.done1;
`endif
      end
      @(negedge clk);
      if (bus.done0 && bus.done1) begin
        total++;
        bad++;
        $display("FAIL contention_both_done: cycle %0d got d0=1 d1=1 want at most one", cyc);
      end else if (bus.done0 || bus.done1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL contention_extra: cycle %0d port %0d got grant want none", cyc, bus.done1);
        end else begin
          e = exp_q.pop_front();
          if ({cyc[6:0], bus.done1} !== e) begin
            bad++;
            $display("FAIL contention_grant: got cycle %0d port %0d want cycle %0d port %0d",
                     cyc, bus.done1, e[7:1], e[0]);
          end
        end
      end
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL contention_missing: got %0d grants short want 0", exp_q.size());
    end
    @(posedge clk); #1;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    guard = 0;
    @(negedge clk);
    while (bus.busy && guard < 6) begin
      @(negedge clk);
      guard++;
    end
    total++;
    if (bus.busy !== 1'b0) begin
      bad++;
      $display("FAIL contention_drain: busy got %b want 0 within 6 cycles", bus.busy);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'hA500_0000 | i;
    test_reset();
    test_store_load();
    test_back_to_back();
    test_misaligned();
    test_reset_mid_access();
    test_withdraw();
    test_contention();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
